// File: rtl/everloop_pkg.sv
// Shared definitions for the Everloop LED ring sequencer.
// Build option: define EVERLOOP_RGBW_EN to transmit the W byte (32 bits per
// LED, SK6812 RGBW rings); leave it undefined for GRB-only rings (24 bits).
package everloop_pkg;

  // Frame sequencer states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SEND  = 2'd2,
    ST_LATCH = 2'd3
  } state_t;

  // Default timing for a 50 MHz clock
  localparam int N_LEDS_DEF       = 35;
  localparam int T_BIT_DEF        = 62;    // 800 kHz bit rate
  localparam int T0H_DEF          = 20;
  localparam int T1H_DEF          = 40;
  localparam int RESET_CYCLES_DEF = 3000;  // 60 us latch gap

  // Colour byte positions inside a pixel word: G R B W, MSB first
  localparam int G_LSB = 24;
  localparam int R_LSB = 16;
  localparam int B_LSB = 8;
  localparam int W_LSB = 0;

  // First transmitted bit is the G MSB; the last one depends on the ring type
  localparam int TX_MSB = G_LSB + 7;
`ifdef EVERLOOP_RGBW_EN
  localparam int TX_LSB = W_LSB;
`else
  localparam int TX_LSB = B_LSB;
`endif
  localparam int BPL = TX_MSB - TX_LSB + 1;

  // Packs four colour bytes into the pixel word layout
  function automatic logic [31:0] pack_grbw(input logic [7:0] g, input logic [7:0] r,
                                            input logic [7:0] b, input logic [7:0] w);
    logic [31:0] word;
    word = '0;
    word[G_LSB +: 8] = g;
    word[R_LSB +: 8] = r;
    word[B_LSB +: 8] = b;
    word[W_LSB +: 8] = w;
    return word;
  endfunction

endpackage

// File: rtl/everloop_ctrl_if.sv
// Host-side bus of the Everloop sequencer: pixel writes, frame start/status
// and the serial LED line.
//
// Handshake: wr_en has no back-pressure; a write is taken on every edge it is
// high (addresses >= N_LEDS are dropped). start is a single-cycle request that
// is accepted on an edge where busy is low and ignored otherwise; busy high
// means "not ready", and done pulses for one cycle as busy falls.
interface everloop_ctrl_if;
  logic        wr_en;
  logic [5:0]  wr_addr;
  logic [31:0] wr_data;
  logic        start;
  logic        busy;
  logic        done;
  logic        led_ctl;

  modport master (
    output wr_en, wr_addr, wr_data, start,
    input  busy, done, led_ctl
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, start,
    output busy, done, led_ctl
  );
endinterface

// File: rtl/everloop_bit_tx.sv
// Single-wire NRZ bit encoder: each slot is T_BIT cycles, high for T1H (one)
// or T0H (zero) cycles from the slot start, low for the rest. A bit_go in the
// final cycle of a slot chains the next slot with no gap.
module everloop_bit_tx
  import everloop_pkg::*;
#(
  parameter int T_BIT = T_BIT_DEF,
  parameter int T0H   = T0H_DEF,
  parameter int T1H   = T1H_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic bit_val,
  input  logic bit_go,
  output logic led_ctl,
  output logic bit_last
);

  localparam int CNT_W = (T_BIT > 1) ? $clog2(T_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(T_BIT - 1);
  localparam logic [CNT_W-1:0] HI_ZERO  = CNT_W'(T0H);
  localparam logic [CNT_W-1:0] HI_ONE   = CNT_W'(T1H);

  if (!(T0H > 0 && T0H < T1H && T1H < T_BIT)) begin : g_bad_timing
    $error("everloop_bit_tx: timing must satisfy 0 < T0H < T1H < T_BIT");
  end

  logic             active_q, active_d;
  logic             val_q, val_d;
  logic             led_q, led_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_nx;

  assign cnt_nx = cnt_q + 1'b1;

  // Slot timer: led_q always holds the level for the cycle counted by cnt_q
  always_comb begin
    active_d = active_q;
    val_d    = val_q;
    led_d    = led_q;
    cnt_d    = cnt_q;
    if (bit_go) begin
      active_d = 1'b1;
      val_d    = bit_val;
      cnt_d    = '0;
      led_d    = 1'b1;
    end else if (active_q) begin
      if (cnt_q == CNT_LAST) begin
        active_d = 1'b0;
        cnt_d    = '0;
        led_d    = 1'b0;
      end else begin
        cnt_d = cnt_nx;
        led_d = (cnt_nx < (val_q ? HI_ONE : HI_ZERO));
      end
    end
  end

  // Timer registers
  always_ff @(posedge clk) begin
    if (rst) begin
      active_q <= 1'b0;
      val_q    <= 1'b0;
      led_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      active_q <= active_d;
      val_q    <= val_d;
      led_q    <= led_d;
      cnt_q    <= cnt_d;
    end
  end

  assign led_ctl  = led_q;
  assign bit_last = active_q && (cnt_q == CNT_LAST);

endmodule

// File: rtl/everloop_ctrl.sv
// Everloop ring frame sequencer: pixel RAM, shift register, pixel/bit/latch
// counters and the IDLE/LOAD/SEND/LATCH FSM. Streams every pixel MSB first
// through everloop_bit_tx, then holds the line low for the latch gap.
// Bits per LED follow EVERLOOP_RGBW_EN (see everloop_pkg).
module everloop_ctrl
  import everloop_pkg::*;
#(
  parameter int N_LEDS       = N_LEDS_DEF,
  parameter int T_BIT        = T_BIT_DEF,
  parameter int T0H          = T0H_DEF,
  parameter int T1H          = T1H_DEF,
  parameter int RESET_CYCLES = RESET_CYCLES_DEF
) (
  input  logic   clk,
  input  logic   rst,
  everloop_ctrl_if.slave bus,
  output state_t state_o
);

  localparam int PIX_W = (N_LEDS > 1) ? $clog2(N_LEDS) : 1;
  localparam int BIT_W = $clog2(BPL);
  localparam int LAT_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

  if (N_LEDS < 1 || N_LEDS > 64 || RESET_CYCLES < 1) begin : g_bad_cfg
    $error("everloop_ctrl: N_LEDS must be 1..64 and RESET_CYCLES >= 1");
  end

  logic [31:0]      ram_q [N_LEDS];
  state_t           state_q, state_d;
  logic [31:0]      shift_q, shift_d;
  logic [31:0]      rd_q, rd_d, rd_word;
  logic [PIX_W-1:0] pix_q, pix_d, rd_addr;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic [LAT_W-1:0] lat_q, lat_d;
  logic             first_q, done_q, done_d;
  logic             busy, bit_go, bit_val, bit_last, led_ctl;
  logic             last_bit, last_pix, frame_end, latch_end, wr_ok;

  assign wr_ok     = bus.wr_en && (32'(bus.wr_addr) < 32'(N_LEDS));
  assign last_bit  = (bit_q == BIT_W'(BPL - 1));
  assign last_pix  = (pix_q == PIX_W'(N_LEDS - 1));
  assign frame_end = (state_q == ST_SEND) && bit_last && last_bit && last_pix;
  assign latch_end = (lat_q == LAT_W'(RESET_CYCLES - 1));

  // Pixel RAM read port: pixel 0 while idle, otherwise the next pixel
  // (consumed on the final edge of the current pixel's last bit)
  assign rd_addr = ((state_q == ST_SEND) && !last_pix) ? pix_q + 1'b1 : '0;
  assign rd_word = ram_q[rd_addr];

  // Host writes land in any state; reads on the same edge see the old word
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      ram_q[bus.wr_addr[PIX_W-1:0]] <= bus.wr_data;
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (bus.start) state_d = ST_LOAD;
      ST_LOAD:  state_d = ST_SEND;
      ST_SEND:  if (frame_end) state_d = ST_LATCH;
      ST_LATCH: if (latch_end) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // FSM outputs and datapath next values
  always_comb begin
    busy    = (state_q != ST_IDLE);
    bit_go  = (state_q == ST_SEND) && (first_q || (bit_last && !(last_bit && last_pix)));
    done_d  = (state_q == ST_LATCH) && latch_end;
    rd_d    = ((state_q == ST_IDLE) && bus.start) ? rd_word : rd_q;
    shift_d = shift_q;
    pix_d   = '0;
    bit_d   = '0;
    lat_d   = '0;
    case (state_q)
      ST_LOAD: shift_d = rd_q;
      ST_SEND: begin
        pix_d = pix_q;
        bit_d = bit_q;
        if (bit_last && !frame_end) begin
          if (last_bit) begin
            shift_d = rd_word;
            bit_d   = '0;
            pix_d   = pix_q + 1'b1;
          end else begin
            shift_d = shift_q << 1;
            bit_d   = bit_q + 1'b1;
          end
        end
      end
      ST_LATCH: lat_d = lat_q + 1'b1;
      default: ;
    endcase
  end

  // The encoder samples the bit that the shift register is about to present
  assign bit_val = shift_d[TX_MSB];

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q <= '0;
      rd_q    <= '0;
      pix_q   <= '0;
      bit_q   <= '0;
      lat_q   <= '0;
      first_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      shift_q <= shift_d;
      rd_q    <= rd_d;
      pix_q   <= pix_d;
      bit_q   <= bit_d;
      lat_q   <= lat_d;
      first_q <= (state_q == ST_LOAD);
      done_q  <= done_d;
    end
  end

  everloop_bit_tx #(
    .T_BIT (T_BIT),
    .T0H   (T0H),
    .T1H   (T1H)
  ) u_bit_tx (
    .clk      (clk),
    .rst      (rst),
    .bit_val  (bit_val),
    .bit_go   (bit_go),
    .led_ctl  (led_ctl),
    .bit_last (bit_last)
  );

  assign bus.busy    = busy;
  assign bus.done    = done_q;
  assign bus.led_ctl = led_ctl;
  assign state_o     = state_q;

endmodule
